// File: rtl/packet_dispatcher_pkg.sv
// Shared parameters and helpers for the N-port to M-queue packet dispatcher.
package packet_dispatcher_pkg;

   localparam int DEF_PORTS         = 2;
   localparam int DEF_QUEUES        = 4;
   localparam int DEF_DATA_SIZE     = 678;
   localparam int DEF_COUNTER_WIDTH = 32;

   typedef int unsigned port_idx_t;
   typedef int unsigned queue_idx_t;

   // Index width that never collapses to zero bits for single-entry ranges.
   function automatic int qid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/packet_dispatcher_if.sv
// Packetizer-side and queue-side handshake bundle of the packet dispatcher.
interface packet_dispatcher_if
   import packet_dispatcher_pkg::*;
#(
   parameter int NUMBER_OF_PORTS  = DEF_PORTS,
   parameter int NUMBER_OF_QUEUES = DEF_QUEUES,
   parameter int DATA_SIZE        = DEF_DATA_SIZE
);
   localparam int QID_W = qid_width(NUMBER_OF_QUEUES);

   logic [NUMBER_OF_PORTS*DATA_SIZE-1:0]  in_packet;
   logic [NUMBER_OF_PORTS-1:0]            in_valid;
   logic [NUMBER_OF_PORTS*QID_W-1:0]      in_id;
   logic [NUMBER_OF_PORTS-1:0]            in_ready;
   logic [NUMBER_OF_QUEUES*DATA_SIZE-1:0] out_packet;
   logic [NUMBER_OF_QUEUES-1:0]           out_valid;
   logic [NUMBER_OF_QUEUES-1:0]           queue_ready;

   modport master (
      output in_packet, in_valid, in_id, queue_ready,
      input  in_ready, out_packet, out_valid
   );

   modport slave (
      input  in_packet, in_valid, in_id, queue_ready,
      output in_ready, out_packet, out_valid
   );

endinterface

// File: rtl/packet_dispatcher_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping to the lowest.
module rr_arbiter
   import packet_dispatcher_pkg::*;
#(
   parameter int N  = DEF_PORTS,
   parameter int IW = qid_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          enable,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          found
);
   logic [N-1:0]         upper;
   logic [N-1:0]         upper_req;
   logic [N-1:0]         upper_pick;
   logic [N-1:0]         all_pick;
   logic [N-1:0]         pick;
   logic [IW-1:0][N-1:0] idx_bits;

   genvar p, b;
   for (p = 0; p < N; p++) begin : g_upper
      assign upper[p] = (IW'(p) >= ptr);
   end

   // x & (~x + 1) isolates the lowest set bit; the upper half wins if it has any request.
   assign upper_req  = req & upper;
   assign upper_pick = upper_req & (~upper_req + N'(1));
   assign all_pick   = req & (~req + N'(1));
   assign pick       = (|upper_req) ? upper_pick : all_pick;

   assign grant = enable ? pick : '0;
   assign found = |req;

   for (b = 0; b < IW; b++) begin : g_enc_bit
      for (p = 0; p < N; p++) begin : g_enc_port
         if (((p >> b) & 1) == 1) begin : g_one
            assign idx_bits[b][p] = pick[p];
         end else begin : g_zero
            assign idx_bits[b][p] = 1'b0;
         end
      end
      assign grant_idx[b] = |idx_bits[b];
   end

endmodule

// File: rtl/packet_dispatcher.sv
// N-port to M-queue dispatcher: per-queue round-robin arbitration, registered outputs,
// saturating acceptance counters and a sticky invalid-destination flag.
module packet_dispatcher
   import packet_dispatcher_pkg::*;
#(
   parameter int NUMBER_OF_PORTS  = DEF_PORTS,
   parameter int NUMBER_OF_QUEUES = DEF_QUEUES,
   parameter int DATA_SIZE        = DEF_DATA_SIZE,
   parameter int COUNTER_WIDTH    = DEF_COUNTER_WIDTH
) (
   input  logic                                      clock,
   input  logic                                      reset,
   packet_dispatcher_if.slave                        bus,
   input  logic                                      counters_clear,
   output logic [NUMBER_OF_QUEUES*COUNTER_WIDTH-1:0] accepted_count,
   output logic                                      bad_id_error
);
   localparam int N  = NUMBER_OF_PORTS;
   localparam int M  = NUMBER_OF_QUEUES;
   localparam int D  = DATA_SIZE;
   localparam int CW = COUNTER_WIDTH;
   localparam int QW = qid_width(M);
   localparam int PW = qid_width(N);

   logic [M-1:0][N-1:0] req;
   logic [M-1:0][N-1:0] gnt;
   logic [N-1:0][M-1:0] req_t;
   logic [N-1:0][M-1:0] gnt_t;
   logic [N-1:0]        bad_id;
   logic                err_r;

   genvar p, q;
   for (q = 0; q < M; q++) begin : g_queue
      logic [N:0][D-1:0] mux_acc;
      logic [D-1:0]      pkt_q;
      logic              ov_q;
      logic [PW-1:0]     ptr_q;
      logic [PW-1:0]     gidx_q;
      logic [CW-1:0]     cnt_q;
      logic              found_q;
      logic              slot_free;
      logic              take;

      // One-hot grant makes the AND-OR chain an exact packet mux without in_packet reaching in_ready.
      assign mux_acc[0] = '0;
      for (p = 0; p < N; p++) begin : g_port
         assign req[q][p]    = bus.in_valid[p] && (bus.in_id[p*QW +: QW] == QW'(q));
         assign req_t[p][q]  = req[q][p];
         assign gnt_t[p][q]  = gnt[q][p];
         assign mux_acc[p+1] = mux_acc[p] | ({D{gnt[q][p]}} & bus.in_packet[p*D +: D]);
      end

      assign slot_free = !ov_q || bus.queue_ready[q];
      assign take      = found_q && slot_free;

      rr_arbiter #(.N(N)) u_arb (
         .req       (req[q]),
         .ptr       (ptr_q),
         .enable    (slot_free),
         .grant     (gnt[q]),
         .grant_idx (gidx_q),
         .found     (found_q)
      );

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            pkt_q <= '0;
            ov_q  <= 1'b0;
            ptr_q <= '0;
            cnt_q <= '0;
         end else begin
            if (take) begin
               pkt_q <= mux_acc[N];
               ov_q  <= 1'b1;
               ptr_q <= (gidx_q == PW'(N-1)) ? '0 : gidx_q + PW'(1);
            end else if (bus.queue_ready[q]) begin
               ov_q <= 1'b0;
            end
            if (counters_clear) begin
               cnt_q <= '0;
            end else if (take && (cnt_q != '1)) begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end

      assign bus.out_packet[q*D +: D]    = pkt_q;
      assign bus.out_valid[q]            = ov_q;
      assign accepted_count[q*CW +: CW]  = cnt_q;
   end

   // An id that matches no queue is out of range; such packets are consumed and dropped.
   for (p = 0; p < N; p++) begin : g_ready
      assign bad_id[p]       = bus.in_valid[p] && !(|req_t[p]);
      assign bus.in_ready[p] = reset && (bad_id[p] || (|gnt_t[p]));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_r <= 1'b0;
      end else if (counters_clear) begin
         err_r <= 1'b0;
      end else if (|bad_id) begin
         err_r <= 1'b1;
      end
   end

   assign bad_id_error = err_r;

endmodule

// File: tb/tb_packet_dispatcher.sv
// Self-checking bench for packet_dispatcher: hand-derived vector table, corner sequences,
// and random traffic compared against a queue-level reference model.
module tb_packet_dispatcher;
   import packet_dispatcher_pkg::*;

   localparam int N    = 3;
   localparam int M    = 3;
   localparam int D    = 16;
   localparam int CW   = 4;
   localparam int QW   = qid_width(M);
   localparam int CMAX = (1 << CW) - 1;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            counters_clear = 1'b0;
   logic [M*CW-1:0] accepted_count;
   logic            bad_id_error;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   packet_dispatcher_if #(.NUMBER_OF_PORTS(N), .NUMBER_OF_QUEUES(M), .DATA_SIZE(D)) bus ();

   packet_dispatcher #(
      .NUMBER_OF_PORTS  (N),
      .NUMBER_OF_QUEUES (M),
      .DATA_SIZE        (D),
      .COUNTER_WIDTH    (CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus.slave),
      .counters_clear (counters_clear),
      .accepted_count (accepted_count),
      .bad_id_error   (bad_id_error)
   );

   // reference model state
   logic [D-1:0] m_pkt [M];
   bit           m_ov  [M];
   int           m_ptr [M];
   int           m_cnt [M];
   int           m_win [M];
   bit           m_err;
   logic [N-1:0] m_rdy;

   typedef struct {
      logic [N-1:0]    valid;
      logic [N*QW-1:0] ids;
      logic [M-1:0]    qr;
      logic            clr;
      logic [N-1:0]    exp_ready;
      logic [M-1:0]    exp_ov;
      logic            exp_err;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int id_of(input int p);
      return int'(bus.in_id[p*QW +: QW]);
   endfunction

   function automatic void model_reset();
      for (int q = 0; q < M; q++) begin
         m_pkt[q] = '0;
         m_ov[q]  = 1'b0;
         m_ptr[q] = 0;
         m_cnt[q] = 0;
         m_win[q] = -1;
      end
      m_err = 1'b0;
   endfunction

   // Which port each queue takes this cycle and which ports see ready.
   function automatic void model_eval();
      int p;
      m_rdy = '0;
      for (int q = 0; q < M; q++) begin
         m_win[q] = -1;
         if (!m_ov[q] || bus.queue_ready[q]) begin
            for (int k = 0; k < N; k++) begin
               p = (m_ptr[q] + k) % N;
               if (m_win[q] < 0 && bus.in_valid[p] && id_of(p) == q) m_win[q] = p;
            end
         end
         if (m_win[q] >= 0) m_rdy[m_win[q]] = 1'b1;
      end
      for (int i = 0; i < N; i++)
         if (bus.in_valid[i] && id_of(i) >= M) m_rdy[i] = 1'b1;
      if (!reset) m_rdy = '0;
   endfunction

   function automatic void model_commit();
      bit any_bad;
      any_bad = 1'b0;
      for (int i = 0; i < N; i++)
         if (bus.in_valid[i] && id_of(i) >= M) any_bad = 1'b1;
      for (int q = 0; q < M; q++) begin
         if (m_win[q] >= 0) begin
            m_pkt[q] = bus.in_packet[m_win[q]*D +: D];
            m_ov[q]  = 1'b1;
            m_ptr[q] = (m_win[q] + 1) % N;
            if (m_cnt[q] < CMAX) m_cnt[q]++;
         end else if (bus.queue_ready[q]) begin
            m_ov[q] = 1'b0;
         end
      end
      if (counters_clear) begin
         for (int q = 0; q < M; q++) m_cnt[q] = 0;
         m_err = 1'b0;
      end else if (any_bad) begin
         m_err = 1'b1;
      end
   endfunction

   task automatic check_outputs(input string tag);
      for (int q = 0; q < M; q++) begin
         chk($sformatf("%s out_valid[%0d]", tag, q), 32'(bus.out_valid[q]), 32'(m_ov[q]));
         chk($sformatf("%s out_packet[%0d]", tag, q), 32'(bus.out_packet[q*D +: D]), 32'(m_pkt[q]));
         chk($sformatf("%s accepted_count[%0d]", tag, q), 32'(accepted_count[q*CW +: CW]), 32'(m_cnt[q]));
      end
      chk({tag, " bad_id_error"}, 32'(bad_id_error), 32'(m_err));
   endtask

   task automatic cycle(input string tag);
      #1;
      model_eval();
      chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(m_rdy));
      @(posedge clock);
      model_commit();
      #1;
      check_outputs(tag);
   endtask

   task automatic set_in(input logic [N-1:0] v, input logic [N*QW-1:0] ids,
                         input logic [M-1:0] qr, input logic clr);
      bus.in_valid    = v;
      bus.in_id       = ids;
      bus.queue_ready = qr;
      counters_clear  = clr;
      for (int p = 0; p < N; p++) bus.in_packet[p*D +: D] = D'($urandom);
   endtask

   initial begin
      //                valid    ids {2,1,0}   qr      clr   ready   ov      err
      vecs[0]  = '{3'b011, 6'b00_10_01, 3'b111, 1'b0, 3'b011, 3'b110, 1'b0};
      vecs[1]  = '{3'b000, 6'b00_00_00, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
      vecs[2]  = '{3'b111, 6'b10_10_10, 3'b111, 1'b0, 3'b100, 3'b100, 1'b0};
      vecs[3]  = '{3'b111, 6'b10_10_10, 3'b111, 1'b0, 3'b001, 3'b100, 1'b0};
      vecs[4]  = '{3'b111, 6'b10_10_10, 3'b111, 1'b0, 3'b010, 3'b100, 1'b0};
      vecs[5]  = '{3'b111, 6'b10_10_10, 3'b111, 1'b0, 3'b100, 3'b100, 1'b0};
      vecs[6]  = '{3'b111, 6'b10_10_10, 3'b011, 1'b0, 3'b000, 3'b100, 1'b0};
      vecs[7]  = '{3'b111, 6'b10_10_10, 3'b111, 1'b0, 3'b001, 3'b100, 1'b0};
      vecs[8]  = '{3'b001, 6'b00_00_11, 3'b111, 1'b0, 3'b001, 3'b000, 1'b1};
      vecs[9]  = '{3'b000, 6'b00_00_00, 3'b111, 1'b0, 3'b000, 3'b000, 1'b1};
      vecs[10] = '{3'b010, 6'b00_00_00, 3'b111, 1'b1, 3'b010, 3'b001, 1'b0};
      vecs[11] = '{3'b100, 6'b11_00_00, 3'b111, 1'b1, 3'b100, 3'b000, 1'b0};

      // reset state with traffic present
      model_reset();
      set_in(3'b111, 6'b10_01_00, 3'b111, 1'b0);
      #3;
      chk("reset in_ready", 32'(bus.in_ready), 32'd0);
      check_outputs("reset");

      set_in(3'b000, '0, 3'b111, 1'b0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         set_in(vecs[i].valid, vecs[i].ids, vecs[i].qr, vecs[i].clr);
         #1;
         chk($sformatf("vec%0d ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
         cycle($sformatf("vec%0d", i));
         chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
         chk($sformatf("vec%0d err", i), 32'(bad_id_error), 32'(vecs[i].exp_err));
      end
      chk("table count0", 32'(accepted_count[0 +: CW]), 32'd0);

      // saturation, then clear wins over a same-cycle transfer
      for (int i = 0; i < 20; i++) begin
         set_in(3'b001, 6'b00_00_00, 3'b111, 1'b0);
         cycle("sat");
      end
      chk("sat count0", 32'(accepted_count[0 +: CW]), 32'd15);
      set_in(3'b001, 6'b00_00_00, 3'b111, 1'b1);
      cycle("sat_clr");
      chk("sat_clr count0", 32'(accepted_count[0 +: CW]), 32'd0);

      // asynchronous reset while all three queues hold packets
      set_in(3'b111, 6'b10_01_00, 3'b111, 1'b0);
      cycle("fill");
      chk("fill out_valid", 32'(bus.out_valid), 32'h7);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst in_ready", 32'(bus.in_ready), 32'd0);
      check_outputs("async_rst");
      set_in(3'b000, '0, 3'b111, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle("post_rst");
         chk("post_rst out_valid", 32'(bus.out_valid), 32'd0);
      end

      // random traffic with backpressure, invalid ids and occasional clears
      for (int i = 0; i < 400; i++) begin
         logic [N*QW-1:0] ids;
         logic [M-1:0]    qr;
         for (int p = 0; p < N; p++) ids[p*QW +: QW] = QW'($urandom_range(0, 3));
         for (int q = 0; q < M; q++) qr[q] = ($urandom_range(0, 3) != 0);
         set_in(N'($urandom), ids, qr, ($urandom_range(0, 15) == 0));
         cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
